wb_port_arbiter: RTL and testbench

Round-robin arbiter for the single register-file write port in the RISC-V core. It shares the port between three result producers: ALU result, load data and link (PC+4). It drives the select of the 3:1 writeback mux (`mux31`), along with the write enable and destination register. All grant outputs are registered, so the mux select is glitch-free and stable for the whole write cycle.

---
 rtl/wb_port_arbiter_if.sv | 27 ++
 rtl/wb_port_arbiter.sv | 90 +++++++++
 tb/tb_wb_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port request/grant bundle: three result producers, stall, and the registered mux/RF controls.
interface wb_port_arbiter_if;
    logic       alu_valid;
    logic [4:0] alu_rd;
    logic       alu_ready;
    logic       ld_valid;
    logic [4:0] ld_rd;
    logic       ld_ready;
    logic       lnk_valid;
    logic [4:0] lnk_rd;
    logic       lnk_ready;
    logic       stall;
    logic [1:0] cntrl;
    logic       rf_we;
    logic [4:0] rf_rd;
    logic [2:0] gnt;

    modport master (
        output alu_valid, alu_rd, ld_valid, ld_rd, lnk_valid, lnk_rd, stall,
        input  alu_ready, ld_ready, lnk_ready, cntrl, rf_we, rf_rd, gnt
    );

    modport slave (
        input  alu_valid, alu_rd, ld_valid, ld_rd, lnk_valid, lnk_rd, stall,
        output alu_ready, ld_ready, lnk_ready, cntrl, rf_we, rf_rd, gnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter (alu -> ld -> lnk) for the single register-file write port.
// Latency: 1 cycle from sampled valid to registered grant/write; outputs fully registered.
// Backpressure: stall blocks new grants only; the served requester is excluded for one edge.
module wb_port_arbiter #(
    parameter int         N        = 32,
    parameter logic [1:0] RR_RESET = 2'd2
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    if (N < 1) begin : g_bad_n
        $error("wb_port_arbiter: N must be positive");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [2:0] gnt_q, gnt_nxt;
    logic [1:0] cntrl_q, cntrl_nxt;
    logic       rf_we_q, rf_we_nxt;
    logic [4:0] rf_rd_q, rf_rd_nxt;
    logic [2:0] elig;
    logic [1:0] pick;
    logic [4:0] pick_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= RR_RESET;
            gnt_q   <= 3'b000;
            cntrl_q <= 2'b11;
            rf_we_q <= 1'b0;
            rf_rd_q <= 5'd0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            gnt_q   <= gnt_nxt;
            cntrl_q <= cntrl_nxt;
            rf_we_q <= rf_we_nxt;
            rf_rd_q <= rf_rd_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        last_nxt  = last;
        gnt_nxt   = 3'b000;
        cntrl_nxt = 2'b11;
        rf_we_nxt = 1'b0;
        rf_rd_nxt = 5'd0;

        // The requester served this cycle completes on this edge, so it cannot win again.
        elig = {bus.lnk_valid, bus.ld_valid, bus.alu_valid}
               & ~((state == GRANT) ? gnt_q : 3'b000);

        case (last)
            2'd0:    pick = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
            2'd1:    pick = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
            default: pick = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
        endcase

        case (pick)
            2'd0:    pick_rd = bus.alu_rd;
            2'd1:    pick_rd = bus.ld_rd;
            default: pick_rd = bus.lnk_rd;
        endcase

        if (!bus.stall && (elig != 3'b000)) begin
            state_nxt = GRANT;
            last_nxt  = pick;
            gnt_nxt   = 3'b001 << pick;
            rf_rd_nxt = pick_rd;
            // Writes to x0 are consumed but suppressed; mux parks on its zero input.
            if (pick_rd != 5'd0) begin
                cntrl_nxt = pick;
                rf_we_nxt = 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.alu_ready = gnt_q[0];
    assign bus.ld_ready  = gnt_q[1];
    assign bus.lnk_ready = gnt_q[2];
    assign bus.cntrl     = cntrl_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.N(32), .RR_RESET(2'd2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_cntrl, input logic e_we,
                           input logic [4:0] e_rd, input logic [2:0] e_gnt);
        chk({tag, ".cntrl"}, {6'd0, bus.cntrl}, {6'd0, e_cntrl});
        chk({tag, ".rf_we"}, {7'd0, bus.rf_we}, {7'd0, e_we});
        chk({tag, ".rf_rd"}, {3'd0, bus.rf_rd}, {3'd0, e_rd});
        chk({tag, ".gnt"},   {5'd0, bus.gnt},   {5'd0, e_gnt});
        chk({tag, ".ready"}, {5'd0, bus.lnk_ready, bus.ld_ready, bus.alu_ready}, {5'd0, e_gnt});
    endtask

    task automatic chk_idle(input string tag);
        chk_out(tag, 2'b11, 1'b0, 5'd0, 3'b000);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0;
        bus.lnk_valid = 1'b0; bus.lnk_rd = 5'd0;
        bus.stall     = 1'b0;

        // Reset applied between edges, then held across one edge.
        #1 rst = 1'b1;
        #1 chk_idle("reset_async");
        #6 chk_idle("reset_held");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle("idle");
        end

        // All three valid: last=2 at reset, so rotation starts at alu.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd2;
        bus.lnk_valid = 1'b1; bus.lnk_rd = 5'd3;
        for (int r = 0; r < 2; r++) begin
            tick(); chk_out("rr_alu", 2'b00, 1'b1, 5'd1, 3'b001);
            tick(); chk_out("rr_ld",  2'b01, 1'b1, 5'd2, 3'b010);
            tick(); chk_out("rr_lnk", 2'b10, 1'b1, 5'd3, 3'b100);
        end
        bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; bus.lnk_valid = 1'b0;
        tick(); chk_idle("rr_done");

        // Single ALU request, held through its grant cycle.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5;
        tick(); chk_out("alu_single", 2'b00, 1'b1, 5'd5, 3'b001);
        tick(); chk_idle("alu_excluded");
        bus.alu_valid = 1'b0;
        tick(); chk_idle("alu_dropped");

        // Load under stall for three edges, then released.
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_idle("stall_hold");
        end
        bus.stall = 1'b0;
        tick(); chk_out("stall_release", 2'b01, 1'b1, 5'd4, 3'b010);
        bus.stall = 1'b1;
        #2 chk_out("stall_no_abort", 2'b01, 1'b1, 5'd4, 3'b010);
        tick(); chk_idle("stall_after");
        bus.ld_valid = 1'b0; bus.stall = 1'b0;
        tick(); chk_idle("stall_clear");

        // Link to x0: consumed, no write; last becomes 2 so alu beats ld next.
        bus.lnk_valid = 1'b1; bus.lnk_rd = 5'd0;
        tick(); chk_out("lnk_x0", 2'b11, 1'b0, 5'd0, 3'b100);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd11;
        tick(); chk_out("post_x0_alu", 2'b00, 1'b1, 5'd10, 3'b001);
        bus.lnk_valid = 1'b0;
        tick(); chk_out("post_x0_ld", 2'b01, 1'b1, 5'd11, 3'b010);
        bus.alu_valid = 1'b0;
        tick(); chk_idle("post_x0_idle");
        bus.ld_valid = 1'b0;

        // Reset in the middle of a grant cycle drops the write; request is re-served.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6;
        tick(); chk_out("pre_reset_grant", 2'b00, 1'b1, 5'd6, 3'b001);
        #2 rst = 1'b1;
        #1 chk_idle("mid_grant_reset");
        rst = 1'b0;
        tick(); chk_out("reserve_after_reset", 2'b00, 1'b1, 5'd6, 3'b001);
        bus.alu_valid = 1'b0;
        tick(); chk_idle("reserve_done");

        // One requester continuously valid with new rd each transfer.
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7;
        tick(); chk_out("ld_seq7", 2'b01, 1'b1, 5'd7, 3'b010);
        tick(); chk_idle("ld_gap1");
        bus.ld_rd = 5'd8;
        tick(); chk_out("ld_seq8", 2'b01, 1'b1, 5'd8, 3'b010);
        tick(); chk_idle("ld_gap2");
        bus.ld_rd = 5'd9;
        tick(); chk_out("ld_seq9", 2'b01, 1'b1, 5'd9, 3'b010);
        tick(); chk_idle("ld_gap3");
        bus.ld_valid = 1'b0;
        tick(); chk_idle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
